zigzag_reorder: RTL

- Sits directly downstream of the 8x8 DCT stage.
- Consumes one DCT coefficient stream: 64 coefficients per block, row-major, valid-qualified, no backpressure.
- Re-emits each block in JPEG zigzag order for the quantiser/entropy coder.
- Ping-pong buffered, so one block is written while the previous one is read out at full rate.

---
 rtl/zigzag_reorder_if.sv | 23 ++
 rtl/zigzag_reorder.sv | 126 ++++++++++++
 2 files changed

// File: rtl/zigzag_reorder_if.sv
// Coefficient stream bundle between the DCT stage, the zigzag reorder and the quantiser.
// The master drives row-major coefficients in; the slave returns them in zigzag order.
`timescale 1ns/1ps
interface zigzag_reorder_if #(
  parameter int DATA_WIDTH = 12
);
  logic                         in_valid;
  logic signed [DATA_WIDTH-1:0] in_data;
  logic                         out_valid;
  logic signed [DATA_WIDTH-1:0] out_data;
  logic                         out_first;
  logic                         out_last;

  modport master (
    output in_valid, in_data,
    input  out_valid, out_data, out_first, out_last
  );

  modport slave (
    input  in_valid, in_data,
    output out_valid, out_data, out_first, out_last
  );
endinterface

// File: rtl/zigzag_reorder.sv
// Ping-pong 8x8 block buffer: row-major coefficients in, JPEG zigzag order out.
// One bank fills while the other streams out at one coefficient per cycle.
`timescale 1ns/1ps
module zigzag_reorder #(
  parameter int DATA_WIDTH = 12,
  parameter int BLOCK_SIZE = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  zigzag_reorder_if.slave zz
);

  localparam int         NCOEF = BLOCK_SIZE * BLOCK_SIZE;
  localparam logic [5:0] LAST  = 6'(NCOEF - 1);

  // Raster index for each zigzag position.
  localparam logic [5:0] ZZ [64] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };

  typedef enum logic {IDLE, READ} state_t;

  logic signed [DATA_WIDTH-1:0] mem_a [64];
  logic signed [DATA_WIDTH-1:0] mem_b [64];

  logic [5:0] wcnt;
  logic       wbank;
  logic [1:0] full;

  state_t     state;
  logic       rbank;
  logic [5:0] rcnt;
  logic [5:0] rd_addr;

  logic                         vld_p1;
  logic                         first_p1;
  logic                         last_p1;
  logic signed [DATA_WIDTH-1:0] data_p1;

  logic       wr_done;
  logic       rd_done;
  logic       other_full;
  logic [1:0] wr_set;
  logic [1:0] rd_clr;

  assign wr_done    = zz.in_valid && (wcnt == LAST);
  assign rd_done    = (state == READ) && (rcnt == LAST);
  assign wr_set     = {wr_done & wbank, wr_done & ~wbank};
  assign rd_clr     = {rd_done & rbank, rd_done & ~rbank};
  // A bank completing on the same edge the current readout ends still chains without a bubble.
  assign other_full = full[~rbank] | (wr_done & (wbank != rbank));
  assign rd_addr    = ZZ[rcnt];

  // Write side: fill the current bank in raster order.
  always_ff @(posedge clk) begin
    if (zz.in_valid) begin
      if (wbank) mem_b[wcnt] <= zz.in_data;
      else       mem_a[wcnt] <= zz.in_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wcnt  <= '0;
      wbank <= 1'b0;
      full  <= '0;
    end else begin
      if (zz.in_valid) begin
        wcnt <= wcnt + 6'd1;
        if (wcnt == LAST) wbank <= ~wbank;
      end
      full <= (full & ~rd_clr) | wr_set;
    end
  end

  // Read side: zigzag address issue, synchronous RAM read lands in the output stage (p1).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      rbank    <= 1'b0;
      rcnt     <= '0;
      vld_p1   <= 1'b0;
      first_p1 <= 1'b0;
      last_p1  <= 1'b0;
      data_p1  <= '0;
    end else begin
      case (state)
        IDLE: begin
          vld_p1   <= 1'b0;
          first_p1 <= 1'b0;
          last_p1  <= 1'b0;
          if (|full) begin
            state <= READ;
            rbank <= ~full[0];
            rcnt  <= '0;
          end
        end
        READ: begin
          data_p1  <= rbank ? mem_b[rd_addr] : mem_a[rd_addr];
          vld_p1   <= 1'b1;
          first_p1 <= (rcnt == 6'd0);
          last_p1  <= (rcnt == LAST);
          rcnt     <= rcnt + 6'd1;
          if (rcnt == LAST) begin
            if (other_full) rbank <= ~rbank;
            else            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign zz.out_valid = vld_p1;
  assign zz.out_first = first_p1;
  assign zz.out_last  = last_p1;
  assign zz.out_data  = data_p1;

endmodule
